// File: rtl/fetch_if.sv
// fetch_if -- bundles the fetch controller's external handshakes.
//
// Signals:
//   redirect_valid / redirect_pc : taken branch/jump from the core; restart fetch
//   imem_en / imem_addr          : one-word read request to the instruction memory
//   imem_rdata                   : read data, valid one cycle after imem_en
//   instr_valid / instr_ready    : valid/ready handshake toward decode
//   instr_out / instr_pc         : head instruction word and its byte address
//   instr_fault                  : head entry is a fetch fault entry
//
// Modports:
//   master : the fetch controller
//   slave  : the surrounding core / memory
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_fault;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, instr_ready,
    output imem_en, imem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, instr_ready,
    input  imem_en, imem_addr, instr_valid, instr_out, instr_pc, instr_fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller.
//
// Owns the PC, issues sequential single-word reads to imem (at most one
// outstanding), buffers returned words in a BUF_DEPTH-entry FIFO and hands
// them to decode over a valid/ready handshake. A redirect flushes the FIFO,
// drops any response arriving that cycle and restarts fetch at redirect_pc.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : fetch_if.master (redirect, imem request/response, decode handshake)
//
// Configuration macro FETCH_CTRL_FAULT_CHECK_EN:
//   defined     - misaligned or out-of-range PCs push a single fault entry
//                 (nop word 32'h00000013, fault=1) and park the FSM in HALT
//                 until a redirect.
//   not defined - no checks; imem_addr low two bits forced to zero, fault
//                 output is always 0 and HALT is unreachable.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          BUF_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               infl_q, infl_d;         // one fetch outstanding
  logic [31:0]        infl_addr_q, infl_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  entry_t             fifo_q [BUF_DEPTH];
  entry_t             last_q;                 // last popped entry, shown when empty
  entry_t             head, push_entry;

  logic        issue, push, pop, flush;
  logic        has_space, pc_fault;
  logic [31:0] issue_addr;

`ifdef FETCH_CTRL_FAULT_CHECK_EN
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;
  assign pc_fault   = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) ||
                      ({1'b0, pc_q} >= IMEM_END);
  assign issue_addr = pc_q;
`else
  assign pc_fault   = 1'b0;
  assign issue_addr = {pc_q[31:2], 2'b00};
`endif

  // The in-flight fetch already owns a FIFO slot, so it counts against space.
  assign has_space = (count_q + CNT_W'(infl_q)) < CNT_W'(BUF_DEPTH);

  assign head            = fifo_q[rd_ptr_q];
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_out   = bus.instr_valid ? head.instr : last_q.instr;
  assign bus.instr_pc    = bus.instr_valid ? head.pc    : last_q.pc;
  assign bus.instr_fault = bus.instr_valid ? head.fault : last_q.fault;
  assign bus.imem_en     = issue;
  assign bus.imem_addr   = issue_addr;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    infl_d      = 1'b0;
    infl_addr_d = infl_addr_q;
    issue       = 1'b0;
    push        = infl_q;
    pop         = 1'b0;
    flush       = 1'b0;
    push_entry  = '{instr: bus.imem_rdata, pc: infl_addr_q, fault: 1'b0};

    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (pc_fault) begin
          // Wait for any outstanding response so only one entry is pushed per cycle.
          if (has_space && !infl_q) begin
            push       = 1'b1;
            push_entry = '{instr: 32'h0000_0013, pc: pc_q, fault: 1'b1};
            state_d    = S_HALT;
          end
        end else if (has_space) begin
          issue = 1'b1;
        end
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase

    pop = bus.instr_valid && bus.instr_ready;

    if (issue) begin
      infl_d      = 1'b1;
      infl_addr_d = issue_addr;
      pc_d        = pc_q + 32'd4;
    end

    // Redirect wins over everything: no issue, no push, no pop.
    if (bus.redirect_valid) begin
      flush   = 1'b1;
      issue   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      infl_d  = 1'b0;
      pc_d    = bus.redirect_pc;
      state_d = S_FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          last_q   <= head;
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q guards every read, so stale
  // contents are never visible and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed, table-driven bench for fetch_ctrl with a simple
// one-cycle-latency instruction memory model.
module tb_fetch_ctrl;
  localparam logic [31:0] A = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(
    .RESET_PC  (A),
    .IMEM_BASE (A),
    .IMEM_WORDS(1024),
    .BUF_DEPTH (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] imem [1024];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr[11:2]];

  int errors = 0;
  int checks = 0;
  int n_en;

  typedef struct {
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] out;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [31:0] w(int i);
    case (i)
      0:       return 32'h0010_0093;
      1:       return 32'h0020_0113;
      2:       return 32'h0020_80b3;
      3:       return 32'hffdf_f06f;
      default: return 32'hA000_0000 + 32'(i);
    endcase
  endfunction

  function automatic vec_t mk(logic rdy, logic en, logic [31:0] addr,
                              logic valid, logic [31:0] out, logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.en = en; v.addr = addr; v.valid = valid; v.out = out; v.pc = pc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rv, logic [31:0] rpc, logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (state IDLE).
  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = w(i);
    drive(1'b0, 32'h0, 1'b0);

    // ---- Reset values ---------------------------------------------------
    rst = 1'b1;
    #2;
    check("rst imem_en", bus.imem_en, 0);
    check("rst imem_addr", bus.imem_addr, A);
    check("rst valid", bus.instr_valid, 0);
    check("rst out", bus.instr_out, 0);
    check("rst pc", bus.instr_pc, 0);
    check("rst fault", bus.instr_fault, 0);

    // ---- Table: streaming, then a 10-cycle stall with a partly full FIFO
    vecs.push_back(mk(1, 0, A,          0, 0,    0));       // c0 IDLE
    vecs.push_back(mk(1, 1, A,          0, 0,    0));       // c1 first issue
    vecs.push_back(mk(1, 1, A + 32'h04, 0, 0,    0));
    vecs.push_back(mk(1, 1, A + 32'h08, 1, w(0), A));       // c3 first valid
    vecs.push_back(mk(1, 1, A + 32'h0c, 1, w(1), A + 32'h04));
    vecs.push_back(mk(1, 1, A + 32'h10, 1, w(2), A + 32'h08));
    vecs.push_back(mk(0, 1, A + 32'h14, 1, w(3), A + 32'h0c)); // stall begins
    vecs.push_back(mk(0, 1, A + 32'h18, 1, w(3), A + 32'h0c));
    vecs.push_back(mk(0, 0, A + 32'h1c, 1, w(3), A + 32'h0c)); // full
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0, 0, A + 32'h1c, 1, w(3), A + 32'h0c));
    vecs.push_back(mk(1, 0, A + 32'h1c, 1, w(3), A + 32'h0c)); // release
    vecs.push_back(mk(1, 1, A + 32'h1c, 1, w(4), A + 32'h10));
    vecs.push_back(mk(1, 1, A + 32'h20, 1, w(5), A + 32'h14));
    vecs.push_back(mk(1, 1, A + 32'h24, 1, w(6), A + 32'h18));
    vecs.push_back(mk(1, 1, A + 32'h28, 1, w(7), A + 32'h1c));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, 32'h0, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("row%0d en", i),    bus.imem_en,     vecs[i].en);
      if (vecs[i].en) check($sformatf("row%0d addr", i), bus.imem_addr, vecs[i].addr);
      check($sformatf("row%0d valid", i), bus.instr_valid, vecs[i].valid);
      check($sformatf("row%0d out", i),   bus.instr_out,   vecs[i].out);
      check($sformatf("row%0d pc", i),    bus.instr_pc,    vecs[i].pc);
      check($sformatf("row%0d fault", i), bus.instr_fault, 0);
      step();
    end

    // ---- Stall from reset: exactly four issues, then in-order delivery ---
    do_reset();
    n_en = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (bus.imem_en) n_en++;
      step();
    end
    check("stall en pulses", 32'(n_en), 4);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check($sformatf("drain%0d valid", k), bus.instr_valid, 1);
      check($sformatf("drain%0d out", k), bus.instr_out, w(k));
      check($sformatf("drain%0d pc", k), bus.instr_pc, A + 32'(4 * k));
      if (k == 0) check("drain0 en", bus.imem_en, 0);
      if (k == 1) check("drain1 addr", bus.imem_addr, A + 32'h10);
      step();
    end

    // ---- Redirect with 3 buffered entries and one fetch in flight --------
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(1'b0, 32'h0, 1'b0); step(); end
    drive(1'b1, A + 32'h4, 1'b0);
    @(negedge clk);
    check("redir3 en", bus.imem_en, 0);
    check("redir3 pre out", bus.instr_out, w(0));
    step();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("redir3 R+1 valid", bus.instr_valid, 0);
    check("redir3 R+1 en", bus.imem_en, 1);
    check("redir3 R+1 addr", bus.imem_addr, A + 32'h4);
    step();
    @(negedge clk);
    check("redir3 R+2 valid", bus.instr_valid, 0);
    check("redir3 R+2 addr", bus.imem_addr, A + 32'h8);
    step();
    @(negedge clk);
    check("redir3 R+3 valid", bus.instr_valid, 1);
    check("redir3 R+3 out", bus.instr_out, w(1));
    check("redir3 R+3 pc", bus.instr_pc, A + 32'h4);
    step();
    @(negedge clk);
    check("redir3 R+4 out", bus.instr_out, w(2));
    step();

    // ---- Redirect and pop in the same cycle ------------------------------
    do_reset();
    for (int c = 0; c < 4; c++) begin drive(1'b0, 32'h0, 1'b1); step(); end
    drive(1'b1, A, 1'b1);
    @(negedge clk);
    check("redpop head offered", bus.instr_out, w(1));
    check("redpop en", bus.imem_en, 0);
    step();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("redpop R+1 valid", bus.instr_valid, 0);
    check("redpop R+1 last popped", bus.instr_out, w(0));
    check("redpop R+1 addr", bus.imem_addr, A);
    step();
    @(negedge clk);
    check("redpop R+2 valid", bus.instr_valid, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("redpop seq%0d out", k), bus.instr_out, w(k));
      check($sformatf("redpop seq%0d pc", k), bus.instr_pc, A + 32'(4 * k));
      step();
    end

    // ---- Reset asserted mid-stream --------------------------------------
    do_reset();
    for (int c = 0; c < 6; c++) begin drive(1'b0, 32'h0, 1'b1); step(); end
    #2 rst = 1'b1;
    #1;
    check("midrst en", bus.imem_en, 0);
    check("midrst addr", bus.imem_addr, A);
    check("midrst valid", bus.instr_valid, 0);
    check("midrst out", bus.instr_out, 0);
    check("midrst pc", bus.instr_pc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst c0 en", bus.imem_en, 0);
    step();
    @(negedge clk);
    check("midrst c1 en", bus.imem_en, 1);
    check("midrst c1 addr", bus.imem_addr, A);
    step();
    @(negedge clk);
    check("midrst c2 valid", bus.instr_valid, 0);
    step();
    @(negedge clk);
    check("midrst c3 valid", bus.instr_valid, 1);
    check("midrst c3 out", bus.instr_out, w(0));
    check("midrst c3 pc", bus.instr_pc, A);
    step();

`ifdef FETCH_CTRL_FAULT_CHECK_EN
    // ---- Misaligned redirect -> fault entry, HALT, resume ---------------
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(1'b0, 32'h0, 1'b1); step(); end
    drive(1'b1, A + 32'h2, 1'b0);
    @(negedge clk);
    check("flt R en", bus.imem_en, 0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("flt R+1 en", bus.imem_en, 0);
    check("flt R+1 valid", bus.instr_valid, 0);
    step();
    @(negedge clk);
    check("flt R+2 valid", bus.instr_valid, 1);
    check("flt R+2 out", bus.instr_out, 32'h0000_0013);
    check("flt R+2 pc", bus.instr_pc, A + 32'h2);
    check("flt R+2 fault", bus.instr_fault, 1);
    step();
    n_en = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.imem_en) n_en++;
      step();
    end
    check("halt en pulses", 32'(n_en), 0);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("halt pop valid", bus.instr_valid, 1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("halt empty valid", bus.instr_valid, 0);
    check("halt empty en", bus.imem_en, 0);
    check("halt last fault", bus.instr_fault, 1);
    step();
    drive(1'b1, A, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("resume en", bus.imem_en, 1);
    check("resume addr", bus.imem_addr, A);
    step();
    step();
    @(negedge clk);
    check("resume out", bus.instr_out, w(0));
    check("resume fault", bus.instr_fault, 0);
    step();

    // ---- Top-of-range boundary: last word fetches, next address faults --
    drive(1'b1, A + 32'hffc, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("top last en", bus.imem_en, 1);
    check("top last addr", bus.imem_addr, A + 32'hffc);
    step();
    @(negedge clk);
    check("top end en", bus.imem_en, 0);
    step();
    @(negedge clk);
    check("top last out", bus.instr_out, w(1023));
    check("top last fault", bus.instr_fault, 0);
    step();
    @(negedge clk);
    check("top end fault", bus.instr_fault, 1);
    check("top end pc", bus.instr_pc, A + 32'h1000);
    step();
`else
    // ---- Unaligned redirect without checking: address low bits dropped --
    do_reset();
    for (int c = 0; c < 5; c++) begin drive(1'b0, 32'h0, 1'b1); step(); end
    drive(1'b1, A + 32'h6, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("unal en", bus.imem_en, 1);
    check("unal addr", bus.imem_addr, A + 32'h4);
    step();
    @(negedge clk);
    check("unal next addr", bus.imem_addr, A + 32'h8);
    step();
    @(negedge clk);
    check("unal out", bus.instr_out, w(1));
    check("unal fault", bus.instr_fault, 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller sitting between the core's decode stage and the single-port instruction memory `imem`. It owns the program counter, issues sequential word reads to `imem`, buffers returned instructions in a small FIFO and delivers them to decode over a valid/ready handshake. It also handles control-flow redirects by flushing buffered and in-flight fetches and restarting at the new PC.

## Interface
- `RESET_PC`, default 32'h01000000: PC loaded on reset.
- `IMEM_BASE`, default 32'h01000000: byte address of `imem` word 0.
- `IMEM_WORDS`, default 1024: `imem` depth in 32-bit words.
- `BUF_DEPTH`, default 4: instruction FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch byte address.
- `imem_en`  out  1  fetch issued this cycle.
- `imem_addr`  out  32  byte address of the fetch; valid when `imem_en`=1.
- `imem_rdata`  in  32  instruction word; valid exactly one cycle after the matching `imem_en`.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instr_out`  out  32  head instruction word.
- `instr_pc`  out  32  byte address of the head instruction.
- `instr_fault`  out  1  head is a fetch fault entry (see Configuration).

## Operation
- States: IDLE, FETCH, HALT. Reset → IDLE; IDLE → FETCH unconditionally on the first edge after reset release.
- FETCH issue rule: `imem_en`=1 when state is FETCH, `redirect_valid`=0 and occupancy + in-flight (0/1) < `BUF_DEPTH`. Only one outstanding fetch; `imem_addr`=pc; pc += 4 on issue (32-bit wrap).
- Response: in the cycle after an issue, `imem_rdata` and the issued address are written into the FIFO tail, unless `redirect_valid`=1 in that cycle (response dropped).
- Pop: head removed when `instr_valid` && `instr_ready`. Push and pop in the same cycle are both performed; occupancy unchanged.
- Redirect (any state): FIFO cleared, any response arriving this cycle dropped, no issue this cycle, pc ← `redirect_pc`, state ← FETCH. Redirect overrides push and pop in the same cycle; a head offered that cycle counts as not accepted.
- Fault (with macro): if pc is not 4-aligned or outside [`IMEM_BASE`, `IMEM_BASE`+4·`IMEM_WORDS`), no `imem_en`; instead one entry {`instr_out`=32'h00000013, `instr_pc`=pc, fault=1} is pushed when space permits (same occupancy rule), and state → HALT. HALT issues nothing; only redirect or reset leaves it.
- Outputs `instr_out`/`instr_pc`/`instr_fault` hold the FIFO head; when empty they hold the last popped values (0 after reset).

## Timing
- Reset values: `imem_en`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `instr_fault`=0, pc=`RESET_PC`, occupancy 0, state IDLE.
- First `imem_en` in cycle 1 after reset release (cycle 0 = first edge, IDLE→FETCH).
- Fetch latency: issue in cycle N, data captured at end of N+1, `instr_valid` in N+2.
- With `BUF_DEPTH`=4 and `instr_ready` held high, steady state is one instruction per cycle.
- Redirect in cycle R: `instr_valid`=0 in R+1; first new issue in R+1; first new instruction valid in R+3.
- Full: no issue while occupancy + in-flight = `BUF_DEPTH`; no entry is ever lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously); pending response discarded.

## Configuration
- `FETCH_CTRL_FAULT_CHECK_EN` defined: alignment/range checking, fault entries and HALT state as above.
- Not defined: no checks; `imem_addr` low two bits forced to 0; `instr_fault` tied 0; HALT unreachable; fetch continues indefinitely.

## Test plan
- Reset release, imem preloaded {0x00100093, 0x00200113, 0x002080b3, 0xffdff06f} at 0x01000000, ready=1 → `imem_addr` 0x01000000, 04, 08, 0c in consecutive cycles; outputs in order with matching `instr_pc`, first `instr_valid` in cycle 3.
- `instr_ready`=0 for 10 cycles → exactly 4 `imem_en` pulses, then none; on release four words delivered in order, none dropped.
- Redirect to 0x01000004 while FIFO holds 3 entries and one fetch in flight → next cycle `instr_valid`=0; next delivered instruction 0x00200113 with `instr_pc` 0x01000004.
- Redirect and pop in same cycle → popped head not counted; no stale entry appears afterwards.
- With macro: redirect to 0x01000002 → no `imem_en`, one entry fault=1, `instr_out`=0x00000013, `instr_pc`=0x01000002, then no fetches until redirect to 0x01000000 resumes normally.
- Reset asserted mid-stream → outputs immediately at reset values; after release fetch restarts at 0x01000000.
